// File: rtl/rtc_pkg.sv
// Shared types, digit limits and 24h-to-12h hour mapping for the BCD time-of-day clock.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned HOUR_MAX     = 23;

  // Returns {tens, ones, pm} for a 24-hour BCD hour pair.
  function automatic logic [8:0] hour24_to_12(input bcd_t h1, input bcd_t h2);
    logic [4:0] hr;
    logic [4:0] disp;
    logic       is_pm;
    hr    = 5'(h1) * 5'd10 + 5'(h2);
    is_pm = (hr >= 5'd12);
    if (hr == 5'd0) begin
      disp = 5'd12;
    end else if (hr > 5'd12) begin
      disp = hr - 5'd12;
    end else begin
      disp = hr;
    end
    if (disp >= 5'd10) begin
      return {4'd1, 4'(disp - 5'd10), is_pm};
    end else begin
      return {4'd0, 4'(disp), is_pm};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after {TENS_MAX,ONES_MAX}; load beats inc.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5,
  parameter int unsigned ONES_MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load,
  input  bcd_t load_tens,
  input  bcd_t load_ones,
  output logic wrap_c,
  output bcd_t tens_nxt_c,
  output bcd_t ones_nxt_c,
  output bcd_t tens,
  output bcd_t ones
);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  // Increment result is exposed before the load override so callers see the counted value.
  always_comb begin
    wrap_c     = 1'b0;
    tens_nxt_c = tens_q;
    ones_nxt_c = ones_q;
    if (inc) begin
      if (tens_q == 4'(TENS_MAX) && ones_q == 4'(ONES_MAX)) begin
        tens_nxt_c = 4'd0;
        ones_nxt_c = 4'd0;
        wrap_c     = 1'b1;
      end else if (ones_q == 4'd9) begin
        tens_nxt_c = tens_q + 4'd1;
        ones_nxt_c = 4'd0;
      end else begin
        ones_nxt_c = ones_q + 4'd1;
      end
    end
    tens_d = load ? load_tens : tens_nxt_c;
    ones_d = load ? load_ones : ones_nxt_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/rtc_bcd_clock.sv
// HH:MM:SS BCD time-of-day counter with prescaled tick, validated load,
// 12/24-hour display, rollover strobes and minute-resolution alarm.
module rtc_bcd_clock
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode_12h,
  input  logic        load,
  input  logic [23:0] load_bcd,
  input  logic        alarm_en,
  input  logic [15:0] alarm_hm,
  output logic [3:0]  Hour1,
  output logic [3:0]  Hour2,
  output logic [3:0]  Min1,
  output logic [3:0]  Min2,
  output logic [3:0]  Sec1,
  output logic [3:0]  Sec2,
  output logic        pm,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        hour_pulse,
  output logic        day_pulse,
  output logic        alarm,
  output logic        load_err
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       pulse_q, pulse_d;

  logic tick_c, step_c, load_ok_c;
  logic sec_wrap_c, min_wrap_c, hour_wrap_c;
  bcd_t h1, h2, m1, m2, s1, s2;
  bcd_t h1_nxt, h2_nxt, m1_nxt, m2_nxt, s1_nxt, s2_nxt;
  bcd_t h12_tens, h12_ones;

  bcd_t ld_h1, ld_h2, ld_m1, ld_m2, ld_s1, ld_s2;
  assign {ld_h1, ld_h2, ld_m1, ld_m2, ld_s1, ld_s2} = load_bcd;

  // Hours above 23 are caught by the tens/ones pair check rather than a full compare.
  always_comb begin
    load_ok_c = (ld_h2 <= 4'd9) && (ld_m2 <= 4'd9) && (ld_s2 <= 4'd9)
             && (ld_m1 <= 4'(MIN_TENS_MAX)) && (ld_s1 <= 4'(SEC_TENS_MAX))
             && ((ld_h1 < 4'd2) || (ld_h1 == 4'd2 && ld_h2 <= 4'd3));
    tick_c    = en && (pre_q == PRE_W'(TICK_DIV - 1));
    step_c    = tick_c && !load;
  end

  always_comb begin
    pre_d = pre_q;
    if (load) begin
      if (load_ok_c) pre_d = '0;
    end else if (tick_c) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  bcd_mod_counter #(.TENS_MAX(SEC_TENS_MAX), .ONES_MAX(9)) u_sec (
    .clk(clk), .rst(rst), .inc(step_c), .load(load && load_ok_c),
    .load_tens(ld_s1), .load_ones(ld_s2), .wrap_c(sec_wrap_c),
    .tens_nxt_c(s1_nxt), .ones_nxt_c(s2_nxt), .tens(s1), .ones(s2)
  );

  bcd_mod_counter #(.TENS_MAX(MIN_TENS_MAX), .ONES_MAX(9)) u_min (
    .clk(clk), .rst(rst), .inc(sec_wrap_c), .load(load && load_ok_c),
    .load_tens(ld_m1), .load_ones(ld_m2), .wrap_c(min_wrap_c),
    .tens_nxt_c(m1_nxt), .ones_nxt_c(m2_nxt), .tens(m1), .ones(m2)
  );

  bcd_mod_counter #(.TENS_MAX(HOUR_MAX / 10), .ONES_MAX(HOUR_MAX % 10)) u_hour (
    .clk(clk), .rst(rst), .inc(min_wrap_c), .load(load && load_ok_c),
    .load_tens(ld_h1), .load_ones(ld_h2), .wrap_c(hour_wrap_c),
    .tens_nxt_c(h1_nxt), .ones_nxt_c(h2_nxt), .tens(h1), .ones(h2)
  );

  // Strobe order: {sec, min, hour, day, alarm, load_err}.
  always_comb begin
    pulse_d    = '0;
    pulse_d[5] = step_c;
    pulse_d[4] = sec_wrap_c;
    pulse_d[3] = min_wrap_c;
    pulse_d[2] = hour_wrap_c;
    pulse_d[1] = alarm_en && step_c &&
                 ({h1_nxt, h2_nxt, m1_nxt, m2_nxt, s1_nxt, s2_nxt} == {alarm_hm, 8'h00});
    pulse_d[0] = load && !load_ok_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      pulse_q <= '0;
    end else begin
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
    end
  end

  assign {sec_pulse, min_pulse, hour_pulse, day_pulse, alarm, load_err} = pulse_q;

  // Display hour is a pure function of the hour registers so mode changes never touch the count.
  always_comb begin
    {h12_tens, h12_ones, pm} = hour24_to_12(h1, h2);
    Hour1 = mode_12h ? h12_tens : h1;
    Hour2 = mode_12h ? h12_ones : h2;
  end

  assign Min1 = m1;
  assign Min2 = m2;
  assign Sec1 = s1;
  assign Sec2 = s2;

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Randomized bench for rtc_bcd_clock against a seconds-of-day reference model.
module tb_rtc_bcd_clock;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, mode_12h = 1'b0, load = 1'b0, alarm_en = 1'b0;
  logic [23:0] load_bcd = '0;
  logic [15:0] alarm_hm = '0;
  logic [3:0]  Hour1, Hour2, Min1, Min2, Sec1, Sec2;
  logic        pm, sec_pulse, min_pulse, hour_pulse, day_pulse, alarm, load_err;

  rtc_bcd_clock #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .load(load),
    .load_bcd(load_bcd), .alarm_en(alarm_en), .alarm_hm(alarm_hm),
    .Hour1(Hour1), .Hour2(Hour2), .Min1(Min1), .Min2(Min2), .Sec1(Sec1), .Sec2(Sec2),
    .pm(pm), .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .day_pulse(day_pulse), .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: seconds since midnight, prescaler phase, expected strobes.
  int         m_t  = 0;
  int         m_pc = 0;
  logic [5:0] m_pulse = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_time(input int t, input logic m12);
    int h, m, s, dh;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    dh = h;
    if (m12) begin
      if (h == 0) dh = 12;
      else if (h > 12) dh = h - 12;
    end
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] to_bcd(input int t);
    return exp_time(t, 1'b0);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, " time"}, 32'({Hour1, Hour2, Min1, Min2, Sec1, Sec2}), 32'(exp_time(m_t, mode_12h)));
    check_eq({tag, " pm"}, 32'(pm), 32'(m_t >= 43200));
    check_eq({tag, " pulses"},
             32'({sec_pulse, min_pulse, hour_pulse, day_pulse, alarm, load_err}), 32'(m_pulse));
  endtask

  task automatic model_edge();
    int d[6];
    int nt, ah;
    m_pulse = '0;
    if (load) begin
      for (int i = 0; i < 6; i++) d[i] = int'(load_bcd[23 - 4*i -: 4]);
      if (d[1] <= 9 && d[3] <= 9 && d[5] <= 9 && d[2] <= 5 && d[4] <= 5 &&
          d[0] * 10 + d[1] <= 23) begin
        m_t  = (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
        m_pc = 0;
      end else begin
        m_pulse[0] = 1'b1;
      end
    end else if (en) begin
      if (m_pc == TD - 1) begin
        m_pc = 0;
        nt   = (m_t + 1) % 86400;
        ah   = (int'(alarm_hm[15:12]) * 10 + int'(alarm_hm[11:8])) * 60
             + int'(alarm_hm[7:4]) * 10 + int'(alarm_hm[3:0]);
        m_pulse[5] = 1'b1;
        m_pulse[4] = (nt % 60 == 0);
        m_pulse[3] = (nt % 3600 == 0);
        m_pulse[2] = (nt == 0);
        m_pulse[1] = alarm_en && (nt == ah * 60);
        m_t = nt;
      end else begin
        m_pc++;
      end
    end
  endtask

  task automatic edge_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cyc(input string tag, input logic l, input logic [23:0] lb);
    @(negedge clk);
    load     = l;
    load_bcd = lb;
    edge_check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, load_bcd);
  endtask

  // Reset lands mid-cycle to exercise the asynchronous clear.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    m_t = 0; m_pc = 0; m_pulse = '0;
    check_all({tag, " in_rst"});
    @(negedge clk);
    rst = 1'b0;
    edge_check({tag, " post_rst"});
  endtask

  initial begin
    logic [23:0] lb;
    int t;

    mode_12h = 1'b1;
    do_reset("reset12");
    mode_12h = 1'b0;
    en = 1'b1;
    do_reset("reset");
    idle("count", 15);
    check_eq("count16 time", 32'({Hour1, Hour2, Min1, Min2, Sec1, Sec2}), 32'h000004);

    cyc("daywrap load", 1'b1, 24'h235958);
    idle("daywrap", 2 * TD);

    cyc("badload hour", 1'b1, 24'h240000);
    cyc("badload min", 1'b1, 24'h126000);
    cyc("goodload", 1'b1, 24'h125959);
    idle("after load", 3);

    cyc("lvt load", 1'b1, 24'h101010);
    idle("lvt", TD - 1);
    cyc("lvt collide", 1'b1, 24'h111111);
    idle("lvt after", TD + 1);

    mode_12h = 1'b1;
    cyc("m12 0015", 1'b1, 24'h001500);
    cyc("m12 1200", 1'b1, 24'h120000);
    cyc("m12 1305", 1'b1, 24'h130505);
    for (int i = 0; i < 6; i++) begin
      mode_12h = ~mode_12h;
      idle("m12 toggle", 1);
    end

    mode_12h = 1'b0;
    alarm_hm = 16'h0730;
    alarm_en = 1'b1;
    cyc("alarm load", 1'b1, 24'h072959);
    idle("alarm", TD + 1);
    cyc("alarm direct", 1'b1, 24'h073000);
    idle("alarm direct", TD + 1);
    alarm_en = 1'b0;
    cyc("alarm off", 1'b1, 24'h072959);
    idle("alarm off", TD + 1);

    en = 1'b0;
    idle("frozen", 5);
    cyc("load en low", 1'b1, 24'h015959);
    en = 1'b1;
    idle("resume", TD + 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 9) < 8);
      mode_12h = ($urandom_range(0, 19) == 0) ? ~mode_12h : mode_12h;
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        t = (m_t + 60 * $urandom_range(0, 2)) % 86400;
        lb = to_bcd(t);
        alarm_hm = lb[23:8];
      end
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        t = $urandom_range(0, 86399);
        if ($urandom_range(0, 3) == 0) t = (t / 60) * 60 + 55 + $urandom_range(0, 4);
        load_bcd = to_bcd(t);
      end else begin
        load_bcd = 24'($urandom);
      end
      edge_check("rand");
      if ($urandom_range(0, 499) == 0) do_reset("rand reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
